// File: rtl/debug_run_controller.sv
// debug_run_controller: host-driven run/step/halt sequencer for the pipeline,
// with a PC + register-bank snapshot streamed out byte by byte.
module debug_run_controller #(
    parameter int SIZE          = 32,
    parameter int NUM_REGISTERS = 32,
    parameter bit AUTO_DUMP     = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_cmd_valid,
    input  logic [7:0]                      i_cmd,
    output logic                            o_cmd_ready,
    input  logic                            i_halt,
    input  logic [SIZE-1:0]                 i_pc,
    input  logic [SIZE*NUM_REGISTERS-1:0]   i_registers_debug,
    output logic                            o_stall,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready,
    output logic                            o_busy,
    output logic [2:0]                      o_state
);
    localparam int BYTES = (NUM_REGISTERS + 1) * SIZE / 8;
    localparam int CW    = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, RUN, STEP, DUMP} state_t;

    state_t                   state, nxt;
    logic [CW-1:0]            cnt;
    logic [BYTES*8-1:0]       snap;
    logic [SIZE*NUM_REGISTERS-1:0] ordered;
    logic                     take, last;

    // Reg 0 goes to the top so the snapshot reads out in stream order, MSB first.
    genvar k;
    generate
        for (k = 0; k < NUM_REGISTERS; k++) begin : g_order
            assign ordered[(NUM_REGISTERS-1-k)*SIZE +: SIZE] = i_registers_debug[k*SIZE +: SIZE];
        end
    endgenerate

    assign take      = i_cmd_valid && o_cmd_ready;
    assign last      = cnt == CW'(BYTES - 1);
    assign o_tx_data = snap[BYTES*8-1 -: 8];
    assign o_state   = {1'b0, state};

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = !take ? IDLE :
                        i_cmd == 8'h43 ? RUN :
                        i_cmd == 8'h53 ? STEP :
                        i_cmd == 8'h44 ? DUMP : IDLE;
            RUN:  nxt = i_halt ? (AUTO_DUMP ? DUMP : IDLE) :
                        (take && i_cmd == 8'h48) ? IDLE : RUN;
            STEP: nxt = (i_halt && AUTO_DUMP) ? DUMP : IDLE;
            DUMP: nxt = (i_tx_ready && last) ? IDLE : DUMP;
            default: nxt = IDLE;
        endcase
    end

    // Flags are registered from the next state so every output changes on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_stall     <= 1'b1;
            o_cmd_ready <= 1'b1;
            o_tx_valid  <= 1'b0;
            o_busy      <= 1'b0;
            cnt         <= '0;
            snap        <= '0;
        end else begin
            state       <= nxt;
            o_stall     <= !(nxt == RUN || nxt == STEP);
            o_cmd_ready <= nxt == IDLE || nxt == RUN;
            o_tx_valid  <= nxt == DUMP;
            o_busy      <= nxt == STEP || nxt == DUMP;
            if (state != DUMP && nxt == DUMP) begin
                snap <= {i_pc, ordered};
                cnt  <= '0;
            end else if (state == DUMP && i_tx_ready) begin
                snap <= snap << 8;
                cnt  <= last ? '0 : cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_debug_run_controller.sv
// tb_debug_run_controller: randomized and directed checks of two controllers
// (auto-dump on and off) against a byte-level behavioural model.
module tb_debug_run_controller;
    localparam int SIZE  = 32;
    localparam int NR    = 32;
    localparam int BPW   = SIZE / 8;
    localparam int BYTES = (NR + 1) * BPW;

    logic clk = 0, rst = 1, cmd_valid = 0, halt = 0, tx_ready = 0;
    logic [7:0] cmd = '0;
    logic [SIZE-1:0] pc = '0;
    logic [SIZE*NR-1:0] regs = '0;

    logic a_ready, a_stall, a_valid, a_busy, b_ready, b_stall, b_valid, b_busy;
    logic [7:0] a_data, b_data;
    logic [2:0] a_state, b_state;

    int vectors = 0, miscompares = 0;
    bit armed = 0;
    int stall_lo = 0;

    int m_st[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    logic [7:0] m_snap[2][BYTES];

    always #5 clk = ~clk;

    debug_run_controller #(.SIZE(SIZE), .NUM_REGISTERS(NR), .AUTO_DUMP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(a_ready),
        .i_halt(halt), .i_pc(pc), .i_registers_debug(regs), .o_stall(a_stall),
        .o_tx_data(a_data), .o_tx_valid(a_valid), .i_tx_ready(tx_ready),
        .o_busy(a_busy), .o_state(a_state));

    debug_run_controller #(.SIZE(SIZE), .NUM_REGISTERS(NR), .AUTO_DUMP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(b_ready),
        .i_halt(halt), .i_pc(pc), .i_registers_debug(regs), .o_stall(b_stall),
        .o_tx_data(b_data), .o_tx_valid(b_valid), .i_tx_ready(tx_ready),
        .o_busy(b_busy), .o_state(b_state));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {state, stall, ready, valid, busy, data} derived from the model state.
    function automatic logic [14:0] model_out(input int u);
        int st;
        logic v;
        st = m_st[u];
        v  = st == 3;
        return {3'(st), !(st == 1 || st == 2), (st == 0 || st == 1), v,
                (st == 2 || st == 3), v ? m_snap[u][m_cnt[u]] : 8'h00};
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            bit auto_d, take;
            int st, nst, w;
            logic [SIZE-1:0] word;
            auto_d = (u == 0);
            st = m_st[u];
            if (rst) begin
                m_st[u] = 0;
                m_cnt[u] = 0;
            end else begin
                take = cmd_valid && (st == 0 || st == 1);
                nst = st;
                if (st == 0 && take) begin
                    if (cmd == 8'h43) nst = 1;
                    else if (cmd == 8'h53) nst = 2;
                    else if (cmd == 8'h44) nst = 3;
                end else if (st == 1) begin
                    if (halt) nst = auto_d ? 3 : 0;
                    else if (take && cmd == 8'h48) nst = 0;
                end else if (st == 2) begin
                    nst = (halt && auto_d) ? 3 : 0;
                end else if (st == 3 && tx_ready) begin
                    if (m_cnt[u] == BYTES - 1) begin
                        nst = 0;
                        m_cnt[u] = 0;
                    end else m_cnt[u]++;
                end
                if (st != 3 && nst == 3) begin
                    for (int b = 0; b < BYTES; b++) begin
                        w = b / BPW;
                        word = (w == 0) ? pc : regs[(w-1)*SIZE +: SIZE];
                        m_snap[u][b] = word[(BPW-1 - b % BPW)*8 +: 8];
                    end
                    m_cnt[u] = 0;
                end
                m_st[u] = nst;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("dut_a_outputs", {17'b0, a_state, a_stall, a_ready, a_valid, a_busy, a_data}, {17'b0, model_out(0)});
            chk("dut_b_outputs", {17'b0, b_state, b_stall, b_ready, b_valid, b_busy, b_data}, {17'b0, model_out(1)});
            if (!a_stall) stall_lo++;
        end
    end

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!a_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) chk("cmd_ready_timeout", {31'b0, a_ready}, 32'd1);
        cmd_valid = 1;
        cmd = c;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        tx_ready = 1;
        while ((a_valid || b_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'b0, a_valid | b_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp8[8];
        logic [7:0] pd;
        logic pr;
        int nb, n;
        exp8 = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h11, 8'h00, 8'h00};
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        armed = 1;
        rst = 0;
        repeat (10) @(negedge clk);
        chk("reset_stall", {31'b0, a_stall}, 32'd1);
        chk("reset_tx_valid", {31'b0, a_valid}, 32'd0);
        chk("reset_state", {29'b0, a_state}, 32'd0);
        chk("reset_cmd_ready", {31'b0, a_ready}, 32'd1);

        stall_lo = 0;
        repeat (3) send(8'h53);
        repeat (3) @(negedge clk);
        chk("step_advances", stall_lo, 32'd3);

        send(8'h43);
        repeat (20) @(negedge clk);
        halt = 1;
        @(negedge clk);
        halt = 0;
        chk("halt_auto_dump_state", {29'b0, a_state}, 32'd3);
        chk("halt_no_auto_state", {29'b0, b_state}, 32'd0);
        chk("halt_stall", {31'b0, a_stall}, 32'd1);
        tx_ready = 1;
        nb = 0;
        n = 0;
        while (a_valid && n < 1000) begin
            nb++;
            n++;
            @(negedge clk);
        end
        chk("halt_dump_bytes", nb, BYTES);

        for (int k = 0; k < NR; k++) regs[k*SIZE +: SIZE] = 32'h11110000 + k;
        pc = 32'h40;
        send(8'h44);
        n = 0;
        while (a_valid && n < 1000) begin
            q.push_back(a_data);
            n++;
            @(negedge clk);
        end
        chk("dump_len", q.size(), BYTES);
        if (q.size() == BYTES) begin
            for (int i = 0; i < 8; i++) chk($sformatf("dump_byte%0d", i), {24'b0, q[i]}, {24'b0, exp8[i]});
            chk("dump_byte128", {24'b0, q[128]}, 32'h11);
            chk("dump_byte131", {24'b0, q[131]}, 32'h1F);
        end

        for (int k = 0; k < NR; k++) regs[k*SIZE +: SIZE] = $urandom;
        pc = $urandom;
        tx_ready = 0;
        send(8'h44);
        for (int i = 0; i < 3000 && a_valid; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            pd = a_data;
            pr = tx_ready;
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NR-1)*SIZE +: SIZE] = $urandom;
            if ($urandom_range(0, 7) == 0) pc = $urandom;
            cmd_valid = (i == 30);
            cmd = 8'h43;
            @(negedge clk);
            if (!pr) chk("hold_data", {24'b0, a_data}, {24'b0, pd});
            if (i == 30) chk("cmd_ignored_in_dump", {29'b0, a_state}, 32'd3);
        end
        cmd_valid = 0;
        chk("random_dump_done", {31'b0, a_valid}, 32'd0);
        drain();

        send(8'h43);
        @(negedge clk);
        halt = 1;
        cmd_valid = 1;
        cmd = 8'h48;
        @(negedge clk);
        halt = 0;
        cmd_valid = 0;
        chk("halt_and_H_no_auto", {29'b0, b_state}, 32'd0);
        chk("halt_and_H_auto", {29'b0, a_state}, 32'd3);
        drain();

        pc = 32'hA5000040;
        tx_ready = 1;
        send(8'h44);
        repeat (50) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_tx_valid", {31'b0, a_valid}, 32'd0);
        chk("abort_state", {29'b0, a_state}, 32'd0);
        chk("abort_tx_data", {24'b0, a_data}, 32'd0);
        send(8'h44);
        chk("restart_byte0", {24'b0, a_data}, 32'hA5);
        drain();

        repeat (3000) begin
            rst = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: cmd = 8'h43;
                1: cmd = 8'h53;
                2: cmd = 8'h48;
                3: cmd = 8'h44;
                default: cmd = 8'($urandom);
            endcase
            halt = ($urandom_range(0, 15) == 0);
            tx_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) pc = $urandom;
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NR-1)*SIZE +: SIZE] = $urandom;
            @(negedge clk);
        end
        rst = 0;
        cmd_valid = 0;
        halt = 0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
